// File: rtl/ropuf_array_gen2.sv
// ropuf_array_gen2: ring-oscillator PUF response generator.
// An LFSR seeded from master_challenge picks one oscillator per bank (or two
// neighbours in bank A), edges of both are counted over a window, and the
// comparison of the two counts becomes one response bit, first bit in the MSB.
// Optional feature: define ROPUF_MASK_EN to add the margin input and the
// resp_mask output (1 where the two counts differ by less than margin).
module ropuf_array_gen2 #(
    parameter int N_RO      = 16,
    parameter int RESP_BITS = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [15:0]          master_challenge,
    input  logic [7:0]           window_len,
    input  logic [N_RO-1:0]      ro_a,
    input  logic [N_RO-1:0]      ro_b,
`ifdef ROPUF_MASK_EN
    input  logic [CNT_W-1:0]     margin,
    output logic [RESP_BITS-1:0] resp_mask,
`endif
    output logic                 ro_en,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
);

    localparam int L  = $clog2(N_RO);
    localparam int BW = $clog2(RESP_BITS);
    localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

    typedef enum logic [2:0] {IDLE, SEED, ARM, MEASURE, SETTLE, COMPARE, DONE} state_t;

    state_t           state;
    logic             mode_r;
    logic [7:0]       win_len_r;
    logic [15:0]      seed_r;
    logic [15:0]      lfsr;
    logic [L-1:0]     idx_a, idx_b;
    logic [L-1:0]     arm_idx_a, arm_idx_b, sel_idx_a, sel_idx_b;
    logic [7:0]       win_cnt;
    logic             settle_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic             sel_a, sel_b;
    logic             sync1_a, sync2_a, prev_a;
    logic             sync1_b, sync2_b, prev_b;
    logic             resp_bit;
`ifdef ROPUF_MASK_EN
    logic [CNT_W-1:0] margin_r;
    logic             mask_bit;
`endif

    // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef ROPUF_MASK_EN
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
        return (x > y) ? x - y : y - x;
    endfunction
`endif

    // Oscillator selection; during ARM the new indices come straight from the LFSR
    // so the synchronisers already sample the new pair on the ARM edge
    always_comb begin
        arm_idx_a = lfsr[L-1:0];
        arm_idx_b = mode_r ? arm_idx_a + L'(1) : lfsr[2*L-1:L];
        sel_idx_a = (state == ARM) ? arm_idx_a : idx_a;
        sel_idx_b = (state == ARM) ? arm_idx_b : idx_b;
        sel_a     = ro_a[sel_idx_a];
        sel_b     = mode_r ? ro_a[sel_idx_b] : ro_b[sel_idx_b];
        cnt_a_nxt = (sync2_a & ~prev_a) ? sat_inc(cnt_a) : cnt_a;
        cnt_b_nxt = (sync2_b & ~prev_b) ? sat_inc(cnt_b) : cnt_b;
        resp_bit  = (cnt_a > cnt_b);
`ifdef ROPUF_MASK_EN
        mask_bit  = (abs_diff(cnt_a, cnt_b) < margin_r);
`endif
    end

    // Two-flop synchronisers plus edge history; on ARM the history is primed high
    // so samples taken under the previous bit's selection never count as an edge
    always_ff @(posedge clk) begin
        sync1_a <= sel_a;
        sync1_b <= sel_b;
        if (state == ARM) begin
            sync2_a <= 1'b1;
            sync2_b <= 1'b1;
            prev_a  <= 1'b1;
            prev_b  <= 1'b1;
        end else begin
            sync2_a <= sync1_a;
            sync2_b <= sync1_b;
            prev_a  <= sync2_a;
            prev_b  <= sync2_b;
        end
    end

    // Sequencer: seed, then per bit arm/measure/settle/compare, with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            win_cnt    <= '0;
            settle_cnt <= 1'b0;
            bit_cnt    <= '0;
            response   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ro_en      <= 1'b0;
`ifdef ROPUF_MASK_EN
            resp_mask  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_r    <= mode;
                        win_len_r <= (window_len == 8'd0) ? 8'd1 : window_len;
                        seed_r    <= master_challenge;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        response  <= '0;
                        bit_cnt   <= '0;
`ifdef ROPUF_MASK_EN
                        margin_r  <= margin;
                        resp_mask <= '0;
`endif
                        state     <= SEED;
                    end
                end
                SEED: begin
                    lfsr  <= (seed_r == 16'h0000) ? ZERO_SEED_SUB : seed_r;
                    ro_en <= 1'b1;
                    state <= ARM;
                end
                ARM: begin
                    idx_a   <= arm_idx_a;
                    idx_b   <= arm_idx_b;
                    cnt_a   <= '0;
                    cnt_b   <= '0;
                    win_cnt <= '0;
                    state   <= MEASURE;
                end
                MEASURE: begin
                    cnt_a   <= cnt_a_nxt;
                    cnt_b   <= cnt_b_nxt;
                    win_cnt <= win_cnt + 8'd1;
                    if (win_cnt == win_len_r - 8'd1) begin
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_a      <= cnt_a_nxt;
                    cnt_b      <= cnt_b_nxt;
                    settle_cnt <= 1'b1;
                    if (settle_cnt) begin
                        ro_en <= 1'b0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    response <= {response[RESP_BITS-2:0], resp_bit};
`ifdef ROPUF_MASK_EN
                    resp_mask <= {resp_mask[RESP_BITS-2:0], mask_bit};
`endif
                    lfsr    <= lfsr_next(lfsr);
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(RESP_BITS - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        ro_en <= 1'b1;
                        state <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
